// File: rtl/divu32_nonrestoring_pkg.sv
// Shared definitions for the non-restoring 32-bit unsigned divider.
// Holds the FSM state encoding, the datapath width, the last iteration
// index and the quotient returned for a zero divisor.
package divu32_nonrestoring_pkg;

  localparam int DIV_W = 32;

  // The count register holds 0..31, so the 32nd iteration runs while
  // count equals this value.
  localparam logic [4:0] ITER_LAST = 5'd31;

  // All-ones quotient reported when the divisor is zero.
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/divu32_nonrestoring_addsub.sv
// 33-bit add/subtract step for the non-restoring divider, plus the
// 32-bit Brent-Kung adder it is built on.
//
// divu_addsub33 ports:
//   a    in  33  signed partial remainder operand
//   b    in  32  unsigned divisor (zero-extended to 33 bits)
//   sub  in  1   1 = a - b, 0 = a + b
//   sum  out 33  result modulo 2^33
//
// bkadder_32 ports:
//   a, b in  32  addends
//   cin  in  1   carry in
//   sum  out 32  a + b + cin (low 32 bits)
//   cout out 1   carry out of bit 31
module bkadder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] prop;
  logic [31:0] gen_pre;
  logic [31:0] prop_pre;
  logic [31:0] carry;

  assign prop = a ^ b;

  // Brent-Kung prefix tree. Carry-in is folded into the bit-0 generate so
  // gen_pre[i] ends up as the carry out of bit i. The up-sweep builds
  // prefixes at positions 2^k-1 granularities; the down-sweep fills the
  // remaining positions from the nearest completed prefix below them.
  always_comb begin
    int j;
    gen_pre  = a & b;
    prop_pre = prop;
    gen_pre[0] = (a[0] & b[0]) | (prop[0] & cin);
    j = 0;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          j = i - (1 << l);
          gen_pre[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[j[4:0]]);
          prop_pre[i] = prop_pre[i] & prop_pre[j[4:0]];
        end
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = 0; i < 32; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          j = i - (1 << l);
          gen_pre[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[j[4:0]]);
          prop_pre[i] = prop_pre[i] & prop_pre[j[4:0]];
        end
      end
    end
  end

  assign carry = {gen_pre[30:0], cin};
  assign sum   = prop ^ carry;
  assign cout  = gen_pre[31];

endmodule

module divu_addsub33 (
  input  logic [32:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  logic [31:0] b_eff;
  logic        cout;

  // Subtraction as a + ~b + 1: invert the operand and inject carry-in.
  assign b_eff = b ^ {32{sub}};

  bkadder_32 u_bkadder (
    .a   (a[31:0]),
    .b   (b_eff),
    .cin (sub),
    .sum (sum[31:0]),
    .cout(cout)
  );

  // Bit 32 of the zero-extended b is 0, or 1 after inversion, so the
  // sign bit is a[32] ^ sub ^ carry.
  assign sum[32] = a[32] ^ sub ^ cout;

endmodule

// File: rtl/divu32_nonrestoring.sv
// Multi-cycle unsigned 32-bit non-restoring divider, one quotient bit per
// clock, with valid/ready handshakes on operands and results.
//
// Ports:
//   clk          in  1   rising-edge clock
//   rst_n        in  1   asynchronous active-low reset
//   in_valid     in  1   dividend/divisor valid
//   in_ready     out 1   block can accept operands (IDLE only)
//   dividend     in  32  unsigned dividend N
//   divisor      in  32  unsigned divisor D
//   out_valid    out 1   quotient/remainder valid
//   out_ready    in  1   consumer accepts result
//   quotient     out 32  N / D (all ones when D == 0)
//   remainder    out 32  N mod D (N when D == 0)
//   div_by_zero  out 1   result came from D == 0
//   busy         out 1   state is not IDLE
module divu32_nonrestoring
  import divu32_nonrestoring_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  state_t           state;
  state_t           state_next;
  logic [DIV_W:0]   p_reg;
  logic [DIV_W-1:0] q_reg;
  logic [DIV_W-1:0] d_reg;
  logic [4:0]       count;

  logic [DIV_W:0]   add_a;
  logic             add_sub;
  logic [DIV_W:0]   add_sum;

  // The single adder is shared: in RUN it takes the shifted {P,Q} top
  // bits and subtracts when the old P is non-negative; in FIX it adds
  // the divisor back to a negative remainder.
  always_comb begin
    add_a   = {p_reg[DIV_W-1:0], q_reg[DIV_W-1]};
    add_sub = ~p_reg[DIV_W];
    if (state == FIX) begin
      add_a   = p_reg;
      add_sub = 1'b0;
    end
  end

  divu_addsub33 u_addsub (
    .a  (add_a),
    .b  (d_reg),
    .sub(add_sub),
    .sum(add_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == ITER_LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs depend only on the registered state.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Datapath and registered result outputs. Results are captured on the
  // FIX edge (or the acceptance edge for D == 0) so they are stable for
  // the whole DONE interval and survive the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg <= dividend;
            d_reg <= divisor;
            p_reg <= '0;
            count <= '0;
            if (divisor == '0) begin
              quotient    <= DBZ_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end
          end
        end
        RUN: begin
          p_reg <= add_sum;
          q_reg <= {q_reg[DIV_W-2:0], ~add_sum[DIV_W]};
          count <= count + 5'd1;
        end
        FIX: begin
          if (p_reg[DIV_W]) begin
            p_reg     <= add_sum;
            remainder <= add_sum[DIV_W-1:0];
          end else begin
            remainder <= p_reg[DIV_W-1:0];
          end
          quotient  <= q_reg;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
